// File: rtl/fixed_point_divider.sv
// Sequential signed Q-format divider: restoring division, one quotient bit per clock,
// with saturation on overflow and divide-by-zero and a start/busy/done handshake.
module fixed_point_divider #(
  parameter int Q = 12,
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic         overflow,
  output logic         div_by_zero
);
  localparam int W  = N - 1 + Q;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W);
  localparam logic [N-2:0]  ONE  = {{(N-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  rem_q;
  logic [W-1:0]  dq_q;
  logic [N-2:0]  bmag_q;
  logic          sign_q;
  logic          dbz_q;
  logic          busy_q;
  logic          done_q;
  logic [N-1:0]  quot_q;
  logic          ovf_q;
  logic          dbz_out_q;

  logic [N-2:0]  amag;
  logic [N-2:0]  bmag;
  logic          bz;
  logic [N-1:0]  rem_shift;
  logic          q_bit;
  logic [N-1:0]  rem_d;
  logic [W-1:0]  dq_d;
  logic          ovf_d;
  logic [N-2:0]  mag_d;
  logic          sign_d;
  logic [N-1:0]  quot_d;

  always_comb begin
    amag      = dividend[N-1] ? (~dividend[N-2:0] + ONE) : dividend[N-2:0];
    bmag      = divisor[N-1]  ? (~divisor[N-2:0] + ONE)  : divisor[N-2:0];
    bz        = (bmag == '0);
    // dq_q shifts dividend bits out of the top while quotient bits enter at the bottom
    rem_shift = {rem_q[N-2:0], dq_q[W-1]};
    q_bit     = (rem_shift >= {1'b0, bmag_q});
    rem_d     = q_bit ? (rem_shift - {1'b0, bmag_q}) : rem_shift;
    dq_d      = {dq_q[W-2:0], q_bit};
    ovf_d     = ~dbz_q & (|dq_q[W-1:N-1]);
    mag_d     = (dbz_q | ovf_d) ? '1 : dq_q[N-2:0];
    sign_d    = sign_q & (mag_d != '0);
    quot_d    = {sign_d, sign_d ? (~mag_d + ONE) : mag_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dq_q      <= '0;
      bmag_q    <= '0;
      sign_q    <= 1'b0;
      dbz_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quot_q    <= '0;
      ovf_q     <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            rem_q   <= '0;
            dq_q    <= {amag, {Q{1'b0}}};
            bmag_q  <= bmag;
            dbz_q   <= bz;
            sign_q  <= bz ? (dividend[N-1] & (amag != '0)) : (dividend[N-1] ^ divisor[N-1]);
            // divide-by-zero skips straight to the last count so done still comes 2 edges later
            cnt_q   <= bz ? (LAST - 1'b1) : '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (cnt_q == LAST) begin
            quot_q    <= quot_d;
            ovf_q     <= ovf_d;
            dbz_out_q <= dbz_q;
            done_q    <= 1'b1;
            state_q   <= FIN;
          end else begin
            if (!dbz_q) begin
              rem_q <= rem_d;
              dq_q  <= dq_d;
            end
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench: directed spec vectors plus randomized traffic, all compared
// cycle by cycle against a transaction-level model of the divider.
module tb_fixed_point_divider;
  localparam int N = 32;
  localparam int Q = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  dividend = '0;
  logic [N-1:0]  divisor = '0;
  logic          busy;
  logic          done;
  logic [N-1:0]  quotient;
  logic          overflow;
  logic          div_by_zero;

  int n_checks = 0;
  int n_fail = 0;

  fixed_point_divider #(.Q(Q), .N(N)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .overflow(overflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Result as {div_by_zero, overflow, quotient}, from plain integer arithmetic.
  function automatic logic [33:0] model_div(input logic [31:0] a, input logic [31:0] b);
    longint unsigned full, amag, bmag, m;
    logic s, ovf, dbz;
    logic [31:0] q;
    full = 64'd1 << 31;
    amag = a[31] ? ((full - {33'd0, a[30:0]}) % full) : {33'd0, a[30:0]};
    bmag = b[31] ? ((full - {33'd0, b[30:0]}) % full) : {33'd0, b[30:0]};
    if (bmag == 0) begin
      dbz = 1'b1;
      ovf = 1'b0;
      m   = full - 1;
      s   = a[31] && (amag != 0);
    end else begin
      dbz = 1'b0;
      m   = (amag << Q) / bmag;
      ovf = (m >= full);
      if (ovf) m = full - 1;
      s   = (a[31] ^ b[31]) && (m != 0);
    end
    q = s ? 32'(full | (full - m)) : 32'(m);
    return {dbz, ovf, q};
  endfunction

  // Cycle-level expectation tracker, sampling at negedge.
  logic        s_rst = 1'b1;
  logic        s_start = 1'b0;
  logic [31:0] s_a = '0;
  logic [31:0] s_b = '0;
  bit          m_busy = 1'b0;
  int          m_done_edge = 0;
  int          cyc = 0;
  logic [33:0] m_res = '0;
  logic [31:0] h_q = '0;
  logic        h_ovf = 1'b0;
  logic        h_dbz = 1'b0;
  int          n_ops = 0;

  always @(negedge clk) begin
    bit was_busy;
    cyc++;
    was_busy = m_busy;
    if (s_rst) begin
      m_busy = 1'b0;
      h_q    = '0;
      h_ovf  = 1'b0;
      h_dbz  = 1'b0;
    end else begin
      if (was_busy && cyc == m_done_edge) begin
        h_q   = m_res[31:0];
        h_ovf = m_res[32];
        h_dbz = m_res[33];
      end
      if (was_busy && cyc == m_done_edge + 1) m_busy = 1'b0;
      if (!was_busy && s_start) begin
        m_res       = model_div(s_a, s_b);
        m_busy      = 1'b1;
        m_done_edge = cyc + (m_res[33] ? 2 : N + Q);
        n_ops++;
      end
    end
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_busy && (cyc == m_done_edge)});
    chk("quotient", quotient, h_q);
    chk("overflow", {31'd0, overflow}, {31'd0, h_ovf});
    chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, h_dbz});
    s_rst   = rst;
    s_start = start;
    s_a     = dividend;
    s_b     = divisor;
  end

  task automatic start_div(input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #2;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_done(input logic [31:0] exp_q, input logic exp_ovf,
                           input logic exp_dbz, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    if (!done) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("lit_quotient", quotient, exp_q);
      chk("lit_overflow", {31'd0, overflow}, {31'd0, exp_ovf});
      chk("lit_div_by_zero", {31'd0, div_by_zero}, {31'd0, exp_dbz});
      if (exp_lat >= 0) chk("latency", 32'(n - 1), 32'(exp_lat));
    end
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_q,
                         input logic exp_ovf, input logic exp_dbz, input int exp_lat);
    start_div(a, b);
    wait_done(exp_q, exp_ovf, exp_dbz, exp_lat);
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(1, 16));
      3: return 32'(-$urandom_range(1, 16));
      4: return 32'h7FFF_FFFF;
      5: return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [33:0] r;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    r = model_div(32'h0000_6000, 32'h0000_2000); chk("model_6_2", r[31:0], 32'h0000_3000);
    r = model_div(32'h0000_1000, 32'h0000_3000); chk("model_1_3", r[31:0], 32'h0000_0555);
    r = model_div(32'h8000_0001, 32'h0000_0001); chk("model_negsat", {r[32], r[30:0]}, 32'h8000_0001);
    r = model_div(32'hFFFF_F000, 32'h0000_0000); chk("model_dbz", {r[33], r[30:0]}, 32'h8000_0001);

    run_div(32'h0000_6000, 32'h0000_2000, 32'h0000_3000, 1'b0, 1'b0, 44);
    run_div(32'hFFFF_D000, 32'h0000_2000, 32'hFFFF_E800, 1'b0, 1'b0, 44);
    run_div(32'hFFFF_D000, 32'hFFFF_E000, 32'h0000_1800, 1'b0, 1'b0, 44);
    run_div(32'h0000_0000, 32'hFFFF_E000, 32'h0000_0000, 1'b0, 1'b0, 44);
    run_div(32'h0000_1000, 32'h0000_3000, 32'h0000_0555, 1'b0, 1'b0, 44);
    run_div(32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 44);
    run_div(32'h8000_0001, 32'h0000_0001, 32'h8000_0001, 1'b1, 1'b0, 44);
    run_div(32'h0000_1000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 2);
    run_div(32'hFFFF_F000, 32'h0000_0000, 32'h8000_0001, 1'b0, 1'b1, 2);

    // A second start mid-operation must be ignored.
    start_div(32'h0000_6000, 32'h0000_2000);
    repeat (9) @(posedge clk);
    #2;
    dividend = 32'h0000_1000;
    divisor  = 32'h0000_3000;
    start    = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(32'h0000_3000, 1'b0, 1'b0, -1);
    repeat (50) @(posedge clk);

    // Reset mid-operation aborts without a done, then a fresh divide completes.
    start_div(32'hFFFF_D000, 32'h0000_2000);
    repeat (18) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    run_div(32'hFFFF_D000, 32'hFFFF_E000, 32'h0000_1800, 1'b0, 1'b0, 44);

    // Random traffic: operands change every cycle, bursts hold start high for back-to-back.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      dividend = rnd_op();
      divisor  = rnd_op();
      start    = ((i / 400) % 2 == 1) || ($urandom_range(0, 3) == 0);
      rst      = ($urandom_range(0, 399) == 0);
    end
    @(posedge clk); #2;
    start = 1'b0;
    rst   = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("ops_accepted_min", 32'(n_ops > 40), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
